// File: rtl/serial_adder_nand_if.sv
// serial_adder_nand_if: start/done handshake and operand/result bus.
// The sub signal exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_adder_nand_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  sum,
        input  cout
    );

    modport slave (
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output sum,
        output cout
    );
endinterface

// File: rtl/serial_adder_nand.sv
// serial_adder_nand: bit-serial LSB-first adder built from NAND half adders.
// Define SERIAL_ADD_SUB_EN to add the sub input (two's complement a - b).
module half_adder_nand (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    logic n1;
    logic n2;
    logic n3;

    assign n1 = ~(x & y);
    assign n2 = ~(x & n1);
    assign n3 = ~(y & n1);
    assign s  = ~(n2 & n3);
    assign c  = ~(n1 & n1);
endmodule

module serial_adder_nand #(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    serial_adder_nand_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             busy_q;
    logic             done_q;
    logic             busy_nx;
    logic             done_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_nx;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;
    logic             c_init;

    logic b_in;
    logic s0;
    logic c0;
    logic s_bit;
    logic c1;
    logic nc0;
    logic nc1;
    logic c_nx;

`ifdef SERIAL_ADD_SUB_EN
    logic sub_q;

    assign b_in   = b_sr[0] ^ sub_q;
    assign c_init = bus.sub;
`else
    assign b_in   = b_sr[0];
    assign c_init = 1'b0;
`endif

    // Full adder: two half adders, carries combined by NAND-based OR.
    half_adder_nand u_ha0 (
        .x (a_sr[0]),
        .y (b_in),
        .s (s0),
        .c (c0)
    );

    half_adder_nand u_ha1 (
        .x (s0),
        .y (c),
        .s (s_bit),
        .c (c1)
    );

    assign nc0  = ~(c0 & c0);
    assign nc1  = ~(c1 & c1);
    assign c_nx = ~(nc0 & nc1);

    assign accept = bus.start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign r_nx   = {s_bit, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = SHIFT;
            SHIFT:   if (last) state_nx = DONE;
            DONE:    state_nx = bus.start ? SHIFT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy_nx = 1'b0;
        done_nx = 1'b0;
        unique case (1'b1)
            (state_nx == SHIFT): busy_nx = 1'b1;
            (state_nx == DONE):  done_nx = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_nx;
            done_q <= done_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q  <= 1'b0;
`endif
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            r_sr  <= '0;
            c     <= c_init;
            cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q <= bus.sub;
`endif
        end else if (state == SHIFT) begin
            a_sr <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            r_sr <= r_nx;
            c    <= c_nx;
            cnt  <= cnt + CW'(1);
            // Results publish only on the completing edge.
            if (last) begin
                sum_q  <= r_nx;
                cout_q <= c_nx;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_nand.sv
// tb_serial_adder_nand: directed checks of the bit-serial adder.
// Subtract and WIDTH=4 exhaustive checks run when SERIAL_ADD_SUB_EN is defined.
module tb_serial_adder_nand;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    serial_adder_nand_if #(.WIDTH(8)) bus ();

    serial_adder_nand #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef SERIAL_ADD_SUB_EN
    serial_adder_nand_if #(.WIDTH(4)) bus4 ();

    serial_adder_nand #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic go(input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub    = 1'b0;
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        bus4.sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_chk += 4;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done got=%b exp=0", bus.done);
        end
        if (bus.sum !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_sum got=%h exp=00", bus.sum);
        end
        if (bus.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cout got=%b exp=0", bus.cout);
        end
    endtask

    task automatic test_first_add;
        go(8'h3C, 8'h5A);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            n_chk += 3;
            if (i <= 8) begin
                if (bus.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL add_busy c%0d got=%b exp=1", i, bus.busy);
                end
                if (bus.done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL add_done c%0d got=%b exp=0", i, bus.done);
                end
                if (bus.sum !== 8'h00) begin
                    n_fail++;
                    $display("FAIL add_hold c%0d got=%h exp=00", i, bus.sum);
                end
            end else begin
                if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL add_end done/busy got=%b%b exp=10",
                             bus.done, bus.busy);
                end
                if (bus.sum !== 8'h96) begin
                    n_fail++;
                    $display("FAIL add_sum got=%h exp=96", bus.sum);
                end
                if (bus.cout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL add_cout got=%b exp=0", bus.cout);
                end
            end
        end
        @(negedge clk);
        n_chk += 2;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL add_pulse got=%b exp=0", bus.done);
        end
        if (bus.sum !== 8'h96) begin
            n_fail++;
            $display("FAIL add_keep got=%h exp=96", bus.sum);
        end
    endtask

    task automatic test_vectors;
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic [8:0] ve [4];
        int         n;
        va = '{8'hA5, 8'hC8, 8'h7F, 8'h00};
        vb = '{8'h5B, 8'h64, 8'h01, 8'h00};
        ve = '{9'h100, 9'h12C, 9'h080, 9'h000};
        for (int k = 0; k < 4; k++) begin
            go(va[k], vb[k]);
            wait_done(n);
            n_chk += 2;
            if (n !== 9) begin
                n_fail++;
                $display("FAIL vec%0d_lat got=%0d exp=9", k, n);
            end
            if ({bus.cout, bus.sum} !== ve[k]) begin
                n_fail++;
                $display("FAIL vec%0d_res got=%h exp=%h",
                         k, {bus.cout, bus.sum}, ve[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        go(8'hFF, 8'h01);
        wait_done(n);
        n_chk += 2;
        if (n !== 9) begin
            n_fail++;
            $display("FAIL b2b_lat got=%0d exp=9", n);
        end
        if ({bus.cout, bus.sum} !== 9'h100) begin
            n_fail++;
            $display("FAIL b2b_first got=%h exp=100", {bus.cout, bus.sum});
        end
        bus.start = 1'b1;
        bus.a     = 8'h80;
        bus.b     = 8'h80;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            n_chk++;
            if (i == 1) begin
                if (bus.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_busy got=%b exp=1", bus.busy);
                end
            end else if (i < 9) begin
                if (bus.done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_early c%0d got=%b exp=0", i, bus.done);
                end
            end else begin
                if (bus.done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_done got=%b exp=1", bus.done);
                end
                n_chk++;
                if ({bus.cout, bus.sum} !== 9'h100) begin
                    n_fail++;
                    $display("FAIL b2b_second got=%h exp=100",
                             {bus.cout, bus.sum});
                end
            end
        end
    endtask

    task automatic test_start_ignored;
        go(8'h11, 8'h22);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (i == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'hFF;
                bus.b     = 8'hFF;
            end
        end
        n_chk += 2;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL ign_done got=%b exp=1", bus.done);
        end
        if ({bus.cout, bus.sum} !== 9'h033) begin
            n_fail++;
            $display("FAIL ign_res got=%h exp=033", {bus.cout, bus.sum});
        end
        @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_after busy/done got=%b%b exp=00",
                     bus.busy, bus.done);
        end
    endtask

    task automatic test_reset_abort;
        int n;
        go(8'h44, 8'h55);
        repeat (4) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus.busy, bus.done, bus.cout, bus.sum} !== 11'h0) begin
            n_fail++;
            $display("FAIL abort_clear got=%h exp=000",
                     {bus.busy, bus.done, bus.cout, bus.sum});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_chk++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet c%0d got=%b%b exp=00",
                         i, bus.done, bus.busy);
            end
        end
        go(8'h12, 8'h34);
        wait_done(n);
        n_chk += 2;
        if (n !== 9) begin
            n_fail++;
            $display("FAIL abort_lat got=%0d exp=9", n);
        end
        if ({bus.cout, bus.sum} !== 9'h046) begin
            n_fail++;
            $display("FAIL abort_res got=%h exp=046", {bus.cout, bus.sum});
        end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub;
        int n;
        bus.sub = 1'b1;
        go(8'h05, 8'h07);
        wait_done(n);
        n_chk++;
        if ({bus.cout, bus.sum} !== 9'h0FE) begin
            n_fail++;
            $display("FAIL sub_neg got=%h exp=0FE", {bus.cout, bus.sum});
        end
        go(8'h07, 8'h05);
        wait_done(n);
        n_chk++;
        if ({bus.cout, bus.sum} !== 9'h102) begin
            n_fail++;
            $display("FAIL sub_pos got=%h exp=102", {bus.cout, bus.sum});
        end
        bus.sub = 1'b0;
        go(8'h3C, 8'h5A);
        wait_done(n);
        n_chk++;
        if ({bus.cout, bus.sum} !== 9'h096) begin
            n_fail++;
            $display("FAIL sub_off got=%h exp=096", {bus.cout, bus.sum});
        end
    endtask

    task automatic test_w4_exhaustive;
        logic [4:0] exp;
        logic [3:0] x;
        logic [3:0] y;
        int         n;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 256; k++) begin
                x = k[7:4];
                y = k[3:0];
                exp = (s == 1) ? ({1'b0, x} + {1'b0, ~y} + 5'd1)
                               : ({1'b0, x} + {1'b0, y});
                @(negedge clk);
                bus4.start = 1'b1;
                bus4.a     = x;
                bus4.b     = y;
                bus4.sub   = (s == 1);
                n = 0;
                for (int i = 1; i <= 20; i++) begin
                    @(negedge clk);
                    bus4.start = 1'b0;
                    if (bus4.done === 1'b1) begin
                        n = i;
                        break;
                    end
                end
                n_chk++;
                if (n !== 5 || {bus4.cout, bus4.sum} !== exp) begin
                    n_fail++;
                    $display("FAIL w4 s%0d %h,%h got=%h lat=%0d exp=%h lat=5",
                             s, x, y, {bus4.cout, bus4.sum}, n, exp);
                end
            end
        end
    endtask
`endif

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_first_add();
        test_vectors();
        test_back_to_back();
        test_start_ignored();
        test_reset_abort();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
        test_w4_exhaustive();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
